cmos_in_axi4s_sync_ctrl: RTL and testbench

//  Sequences the CMOS-in AXI4-Stream coupler FIFO from the native-video side. Measures frame geometry, locks after
//  C_LOCK_FRAMES identical frames, then writes pixels tagged {FIELD,EOL,SOF} into the coupler write port.

---
 rtl/cmos_in_axi4s_pkg.sv | 28 ++
 rtl/cmos_in_timing_meas.sv | 118 +++++++++++
 rtl/cmos_in_axi4s_sync_ctrl.sv | 156 +++++++++++++++
 tb/tb_cmos_in_axi4s_sync_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_in_axi4s_pkg.sv
// Shared definitions for the CMOS-in AXI4-Stream coupler front end.
//   state_t      : sequencer states (IDLE=0, LOCK=1, RUN=2, RESYNC=3)
//   MATCH_CNT_W  : width of the frame-match counter (lock depth 1..7)
//   *_idx()      : sideband bit positions above a W-bit pixel in the FIFO word
package cmos_in_axi4s_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCK   = 2'd1,
      ST_RUN    = 2'd2,
      ST_RESYNC = 2'd3
   } state_t;

   localparam int MATCH_CNT_W = 3;

   function automatic int sof_idx(input int w);
      return w;
   endfunction

   function automatic int eol_idx(input int w);
      return w + 1;
   endfunction

   function automatic int field_idx(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/cmos_in_timing_meas.sv
// Frame geometry measurement and lock detection.
//   clk, rst      : video clock, asynchronous active-high reset
//   ce            : clock enable, all state advances only when 1
//   vsync, de     : raw frame sync (polarity set by C_VSYNC_POL) and data enable
//   vs_rise       : frame-start strobe for this CE cycle (combinational)
//   lock_next     : lock status as it will be after this cycle's update
//   locked        : registered lock status
//   frame_width   : active pixels per line of the last measured frame
//   frame_height  : active lines of the last measured frame
module cmos_in_timing_meas
   import cmos_in_axi4s_pkg::*;
#(
   parameter int unsigned C_HCNT_WIDTH  = 12,
   parameter int unsigned C_VCNT_WIDTH  = 12,
   parameter int unsigned C_LOCK_FRAMES = 2,
   parameter int unsigned C_VSYNC_POL   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    vsync,
   input  logic                    de,
   output logic                    vs_rise,
   output logic                    lock_next,
   output logic                    locked,
   output logic [C_HCNT_WIDTH-1:0] frame_width,
   output logic [C_VCNT_WIDTH-1:0] frame_height
);

   localparam logic [MATCH_CNT_W-1:0]  LOCK_TARGET = MATCH_CNT_W'(C_LOCK_FRAMES);
   localparam logic [C_HCNT_WIDTH-1:0] H_MAX       = '1;
   localparam logic [C_HCNT_WIDTH-1:0] H_MAX_M1    = {{(C_HCNT_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [C_VCNT_WIDTH-1:0] V_MAX       = '1;

   logic                    vs_prev_reg;
   logic                    de_prev_reg;
   logic [C_HCNT_WIDTH-1:0] hcnt_reg;
   logic [C_VCNT_WIDTH-1:0] vcnt_reg;
   logic [C_HCNT_WIDTH-1:0] first_w_reg;
   logic                    mismatch_reg;
   logic [MATCH_CNT_W-1:0]  match_cnt_reg;
   logic [MATCH_CNT_W-1:0]  match_cnt_next;
   logic                    locked_reg;
   logic [C_HCNT_WIDTH-1:0] frame_width_reg;
   logic [C_VCNT_WIDTH-1:0] frame_height_reg;
   logic                    vsync_act;
   logic                    frame_ok;

   assign vsync_act = (C_VSYNC_POL != 0) ? vsync : ~vsync;
   assign vs_rise   = ce & vsync_act & ~vs_prev_reg;

   // A frame counts towards lock only if every line matched the first one and
   // the geometry is non-empty and identical to the previous frame.
   assign frame_ok = ~mismatch_reg && (first_w_reg != '0) && (vcnt_reg != '0) &&
                     (first_w_reg == frame_width_reg) && (vcnt_reg == frame_height_reg);

   always_comb begin
      match_cnt_next = match_cnt_reg;
      if (vs_rise) begin
         if (!frame_ok)
            match_cnt_next = '0;
         else if (match_cnt_reg != LOCK_TARGET)
            match_cnt_next = match_cnt_reg + 1'b1;
      end
   end

   assign lock_next = (match_cnt_next == LOCK_TARGET);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_prev_reg      <= 1'b0;
         de_prev_reg      <= 1'b0;
         hcnt_reg         <= '0;
         vcnt_reg         <= '0;
         first_w_reg      <= '0;
         mismatch_reg     <= 1'b0;
         match_cnt_reg    <= '0;
         locked_reg       <= 1'b0;
         frame_width_reg  <= '0;
         frame_height_reg <= '0;
      end else if (ce) begin
         vs_prev_reg   <= vsync_act;
         de_prev_reg   <= de;
         match_cnt_reg <= match_cnt_next;
         locked_reg    <= lock_next;
         if (vs_rise) begin
            frame_width_reg  <= first_w_reg;
            frame_height_reg <= vcnt_reg;
            hcnt_reg         <= '0;
            vcnt_reg         <= '0;
            first_w_reg      <= '0;
            mismatch_reg     <= 1'b0;
         end else if (de) begin
            if (hcnt_reg != H_MAX)
               hcnt_reg <= hcnt_reg + 1'b1;
            // Reaching the counter ceiling means the width is not measurable.
            if (hcnt_reg >= H_MAX_M1)
               mismatch_reg <= 1'b1;
         end else if (de_prev_reg) begin
            // End of line: the first line of a frame is the reference width.
            hcnt_reg <= '0;
            if (vcnt_reg != V_MAX)
               vcnt_reg <= vcnt_reg + 1'b1;
            else
               mismatch_reg <= 1'b1;
            if (vcnt_reg == '0)
               first_w_reg <= hcnt_reg;
            else if (hcnt_reg != first_w_reg)
               mismatch_reg <= 1'b1;
         end
      end
   end

   assign locked       = locked_reg;
   assign frame_width  = frame_width_reg;
   assign frame_height = frame_height_reg;

endmodule

// File: rtl/cmos_in_axi4s_sync_ctrl.sv
// Sequences the CMOS-in coupler FIFO write port from the native video side.
//   VID_IN_CLK, VID_RESET   : video clock, asynchronous active-high reset
//   VID_CE                  : clock enable
//   VID_VSYNC, VID_ACTIVE_VIDEO, VID_DATA : native video timing and pixels
//   ENABLE                  : software run request
//   FIFO_OVERFLOW           : coupler overflow, forces a resync
//   OVERFLOW_CLR            : clears OVERFLOW_STICKY
//   FIFO_WR_DATA/FIFO_WR_EN : {FIELD,EOL,SOF,pixel} write port (WR_EN held between CE cycles)
//   LOCKED, FRAME_WIDTH, FRAME_HEIGHT, OVERFLOW_STICKY : status
module cmos_in_axi4s_sync_ctrl
   import cmos_in_axi4s_pkg::*;
#(
   parameter int unsigned C_NATIVE_DATA_WIDTH = 24,
   parameter int unsigned C_HCNT_WIDTH        = 12,
   parameter int unsigned C_VCNT_WIDTH        = 12,
   parameter int unsigned C_LOCK_FRAMES       = 2,
   parameter int unsigned C_VSYNC_POL         = 1
) (
   input  logic                             VID_IN_CLK,
   input  logic                             VID_RESET,
   input  logic                             VID_CE,
   input  logic                             VID_VSYNC,
   input  logic                             VID_ACTIVE_VIDEO,
   input  logic [C_NATIVE_DATA_WIDTH-1:0]   VID_DATA,
   input  logic                             ENABLE,
   input  logic                             FIFO_OVERFLOW,
   input  logic                             OVERFLOW_CLR,
   output logic [C_NATIVE_DATA_WIDTH+2:0]   FIFO_WR_DATA,
   output logic                             FIFO_WR_EN,
   output logic                             LOCKED,
   output logic [C_HCNT_WIDTH-1:0]          FRAME_WIDTH,
   output logic [C_VCNT_WIDTH-1:0]          FRAME_HEIGHT,
   output logic                             OVERFLOW_STICKY
);

   localparam int W         = int'(C_NATIVE_DATA_WIDTH);
   localparam int SOF_IDX   = sof_idx(W);
   localparam int EOL_IDX   = eol_idx(W);
   localparam int FIELD_IDX = field_idx(W);

   state_t           state_reg;
   logic             vs_rise;
   logic             lock_next;
   logic             de_d1_reg;
   logic [W-1:0]     data_d1_reg;
   logic             sof_flag_reg;
   logic             wr_en_reg;
   logic [W+2:0]     wr_data_reg;
   logic             wr_en_next;
   logic [W+2:0]     wr_word_next;
   logic             sticky_reg;

   cmos_in_timing_meas #(
      .C_HCNT_WIDTH  (C_HCNT_WIDTH),
      .C_VCNT_WIDTH  (C_VCNT_WIDTH),
      .C_LOCK_FRAMES (C_LOCK_FRAMES),
      .C_VSYNC_POL   (C_VSYNC_POL)
   ) u_meas (
      .clk          (VID_IN_CLK),
      .rst          (VID_RESET),
      .ce           (VID_CE),
      .vsync        (VID_VSYNC),
      .de           (VID_ACTIVE_VIDEO),
      .vs_rise      (vs_rise),
      .lock_next    (lock_next),
      .locked       (LOCKED),
      .frame_width  (FRAME_WIDTH),
      .frame_height (FRAME_HEIGHT)
   );

   // Sequencer. Lock decisions at vs_rise use the lock status updated by that
   // same frame boundary. Outside RUN a software stop takes effect at once;
   // inside RUN the current frame is always allowed to complete.
   always_ff @(posedge VID_IN_CLK or posedge VID_RESET) begin
      if (VID_RESET) begin
         state_reg <= ST_IDLE;
      end else if (VID_CE) begin
         case (state_reg)
            ST_IDLE: begin
               if (ENABLE)
                  state_reg <= ST_LOCK;
            end
            ST_LOCK: begin
               if (!ENABLE)
                  state_reg <= ST_IDLE;
               else if (vs_rise && lock_next)
                  state_reg <= ST_RUN;
            end
            ST_RUN: begin
               if (FIFO_OVERFLOW)
                  state_reg <= ST_RESYNC;
               else if (vs_rise) begin
                  if (!lock_next)
                     state_reg <= ST_LOCK;
                  else if (!ENABLE)
                     state_reg <= ST_IDLE;
               end
            end
            ST_RESYNC: begin
               if (!ENABLE)
                  state_reg <= ST_IDLE;
               else if (vs_rise)
                  state_reg <= lock_next ? ST_RUN : ST_LOCK;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Stage 2 looks at the live DE to see that the stage-1 pixel ends its line.
   assign wr_en_next = de_d1_reg & (state_reg == ST_RUN);

   always_comb begin
      wr_word_next            = '0;
      wr_word_next[W-1:0]     = data_d1_reg;
      wr_word_next[SOF_IDX]   = de_d1_reg & sof_flag_reg;
      wr_word_next[EOL_IDX]   = de_d1_reg & ~VID_ACTIVE_VIDEO;
      wr_word_next[FIELD_IDX] = 1'b0;
   end

   always_ff @(posedge VID_IN_CLK or posedge VID_RESET) begin
      if (VID_RESET) begin
         de_d1_reg    <= 1'b0;
         data_d1_reg  <= '0;
         sof_flag_reg <= 1'b0;
         wr_en_reg    <= 1'b0;
         wr_data_reg  <= '0;
      end else if (VID_CE) begin
         de_d1_reg   <= VID_ACTIVE_VIDEO;
         data_d1_reg <= VID_DATA;
         wr_en_reg   <= wr_en_next;
         wr_data_reg <= wr_word_next;
         // Armed at every frame start, consumed by the first pixel written.
         if (vs_rise)
            sof_flag_reg <= 1'b1;
         else if (wr_en_next)
            sof_flag_reg <= 1'b0;
      end
   end

   always_ff @(posedge VID_IN_CLK or posedge VID_RESET) begin
      if (VID_RESET)
         sticky_reg <= 1'b0;
      else if (VID_CE) begin
         if (FIFO_OVERFLOW)
            sticky_reg <= 1'b1;
         else if (OVERFLOW_CLR)
            sticky_reg <= 1'b0;
      end
   end

   assign FIFO_WR_EN      = wr_en_reg;
   assign FIFO_WR_DATA    = wr_data_reg;
   assign OVERFLOW_STICKY = sticky_reg;

endmodule

// File: tb/tb_cmos_in_axi4s_sync_ctrl.sv
module tb_cmos_in_axi4s_sync_ctrl;

   localparam int W = 24;
   localparam int H = 12;
   localparam int V = 12;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           ce = 1'b1;
   logic           vsync = 1'b0;
   logic           de = 1'b0;
   logic [W-1:0]   data = '0;
   logic           enable = 1'b1;
   logic           ovf = 1'b0;
   logic           ovf_clr = 1'b0;
   logic [W+2:0]   wr_data;
   logic           wr_en;
   logic           locked;
   logic [H-1:0]   fw;
   logic [V-1:0]   fh;
   logic           sticky;

   always #5 clk = ~clk;

   cmos_in_axi4s_sync_ctrl #(
      .C_NATIVE_DATA_WIDTH (W),
      .C_HCNT_WIDTH        (H),
      .C_VCNT_WIDTH        (V),
      .C_LOCK_FRAMES       (2),
      .C_VSYNC_POL         (1)
   ) dut (
      .VID_IN_CLK       (clk),
      .VID_RESET        (rst),
      .VID_CE           (ce),
      .VID_VSYNC        (vsync),
      .VID_ACTIVE_VIDEO (de),
      .VID_DATA         (data),
      .ENABLE           (enable),
      .FIFO_OVERFLOW    (ovf),
      .OVERFLOW_CLR     (ovf_clr),
      .FIFO_WR_DATA     (wr_data),
      .FIFO_WR_EN       (wr_en),
      .LOCKED           (locked),
      .FRAME_WIDTH      (fw),
      .FRAME_HEIGHT     (fh),
      .OVERFLOW_STICKY  (sticky)
   );

   logic [W+2:0] exp_q[$];
   logic [W+2:0] mon_exp;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_writes = 0;
   int           w0;
   bit           ce_toggle = 1'b0;
   bit           sb_off = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a write is one cycle where the coupler sees WR_EN & CE.
   always @(negedge clk) begin
      if (!rst && !sb_off && wr_en && ce) begin
         n_writes++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got %h, expected no write", wr_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (wr_data !== mon_exp) begin
               n_bad++;
               $display("FAIL write_data #%0d: got %h, expected %h", n_writes, wr_data, mon_exp);
            end else
               $display("write #%0d: %h (eol=%0b sof=%0b)", n_writes, wr_data, wr_data[W+1], wr_data[W]);
         end
      end
   end

   // One CE cycle of stimulus; in toggle mode a CE=0 clock follows with inputs held.
   task automatic step(input logic d_e, input logic [W-1:0] d, input logic vs, input logic ov);
      de = d_e; data = d; vsync = vs; ovf = ov; ce = 1'b1;
      @(posedge clk); #1;
      if (ce_toggle) begin
         ce = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   // 8x4 frame (one line may be 7 wide) followed by a vsync pulse.
   // exp_wr: frame is expected to be written; ovf_at / en_drop_at: pixel index or -1.
   task automatic send_frame(input int fid, input bit exp_wr, input int short_line,
                             input int ovf_at, input int en_drop_at);
      int pidx;
      bit first;
      pidx = 0;
      first = 1'b1;
      for (int l = 0; l < 4; l++) begin
         int w;
         w = (l == short_line) ? 7 : 8;
         for (int p = 0; p < w; p++) begin
            logic [W-1:0] d;
            bit ov;
            d = {8'(fid), 8'(l), 8'(p)};
            ov = (pidx == ovf_at);
            if (pidx == en_drop_at) enable = 1'b0;
            if (exp_wr && (ovf_at < 0 || pidx < ovf_at)) begin
               exp_q.push_back({1'b0, (p == w - 1), first, d});
               first = 1'b0;
            end
            step(1'b1, d, 1'b0, ov);
            pidx++;
         end
         repeat (3) step(1'b0, '0, 1'b0, 1'b0);
      end
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b1; ovf = 1'b0; ovf_clr = 1'b0; de = 1'b0; vsync = 1'b0; ce = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Test 1 / test 4 body: three measuring frames, the third locks, the fourth is written.
   task automatic lock_and_stream(input string tag);
      send_frame(1, 1'b0, -1, -1, -1);
      send_frame(2, 1'b0, -1, -1, -1);
      check({tag, "_locked_f2"}, 32'(locked), 0);
      send_frame(3, 1'b0, -1, -1, -1);
      check({tag, "_locked_f3"}, 32'(locked), 1);
      check({tag, "_state_f3"}, 32'(dut.state_reg), 2);
      w0 = n_writes;
      send_frame(4, 1'b1, -1, -1, -1);
      check({tag, "_writes_f4"}, 32'(n_writes - w0), 32);
      check({tag, "_width"}, 32'(fw), 8);
      check({tag, "_height"}, 32'(fh), 4);
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_width", 32'(fw), 0);
      check("rst_height", 32'(fh), 0);
      check("rst_sticky", 32'(sticky), 0);
      check("rst_state", 32'(dut.state_reg), 0);
      rst = 1'b0;

      // Test 1
      lock_and_stream("t1");

      // Test 2: a 7-pixel line breaks lock; two clean frames needed to relock
      w0 = n_writes;
      send_frame(5, 1'b1, 2, -1, -1);
      check("t2_writes_bad", 32'(n_writes - w0), 31);
      check("t2_locked", 32'(locked), 0);
      check("t2_state", 32'(dut.state_reg), 1);
      send_frame(6, 1'b0, -1, -1, -1);
      check("t2_locked_1", 32'(locked), 0);
      send_frame(7, 1'b0, -1, -1, -1);
      check("t2_locked_2", 32'(locked), 1);
      check("t2_state_2", 32'(dut.state_reg), 2);

      // Test 3: overflow at pixel 12 stops writes for the rest of the frame
      w0 = n_writes;
      send_frame(8, 1'b1, -1, 12, -1);
      check("t3_writes_ovf", 32'(n_writes - w0), 12);
      check("t3_sticky", 32'(sticky), 1);
      check("t3_state", 32'(dut.state_reg), 2);
      w0 = n_writes;
      send_frame(9, 1'b1, -1, -1, -1);
      check("t3_writes_resume", 32'(n_writes - w0), 32);
      check("t3_sticky_held", 32'(sticky), 1);
      ovf_clr = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      ovf_clr = 1'b0;
      check("t3_sticky_clr", 32'(sticky), 0);

      // Test 5: ENABLE dropped mid-frame, frame completes, then IDLE
      w0 = n_writes;
      send_frame(10, 1'b1, -1, -1, 10);
      check("t5_writes", 32'(n_writes - w0), 32);
      check("t5_state", 32'(dut.state_reg), 0);
      w0 = n_writes;
      send_frame(11, 1'b0, -1, -1, -1);
      check("t5_writes_idle", 32'(n_writes - w0), 0);

      // Test 4: CE toggling gives the same write sequence as test 1
      do_reset();
      ce_toggle = 1'b1;
      lock_and_stream("t4");
      ce_toggle = 1'b0;

      // Test 6: asynchronous reset mid-line clears outputs without a clock edge
      sb_off = 1'b1;
      for (int p = 0; p < 4; p++) step(1'b1, 24'(p), 1'b0, 1'b0);
      check("t6_wr_en_before", 32'(wr_en), 1);
      check("t6_locked_before", 32'(locked), 1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_wr_en", 32'(wr_en), 0);
      check("t6_wr_data", 32'(wr_data), 0);
      check("t6_locked", 32'(locked), 0);
      check("t6_width", 32'(fw), 0);
      check("t6_height", 32'(fh), 0);
      check("t6_state", 32'(dut.state_reg), 0);
      de = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb_off = 1'b0;
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
